// File: rtl/uart_rx_deser_gen_if.sv
// Output handshake bundle of the UART RX deserializer: held word, valid/ready, status flags.
// Optional par_calc member exists only when UART_RX_PARITY_CALC_EN is defined.
interface uart_rx_deser_gen_if #(
    parameter int MAX_WIDTH = 9
);
    logic [MAX_WIDTH-1:0] P_DATA;
    logic                 data_valid;
    logic                 out_ready;
    logic                 overrun;
    logic                 busy;
`ifdef UART_RX_PARITY_CALC_EN
    logic                 par_calc;
`endif

    modport master (
        input  out_ready,
        output P_DATA, data_valid, overrun, busy
`ifdef UART_RX_PARITY_CALC_EN
        , output par_calc
`endif
    );

    modport slave (
        output out_ready,
        input  P_DATA, data_valid, overrun, busy
`ifdef UART_RX_PARITY_CALC_EN
        , input par_calc
`endif
    );
endinterface

// File: rtl/uart_rx_deser_gen.sv
// UART RX deserializer: run-time frame length, LSB/MSB-first, held output word with overrun.
// Optional feature macro: UART_RX_PARITY_CALC_EN adds the par_calc output.
module uart_rx_deser_gen #(
    parameter int MAX_WIDTH = 9,
    parameter int PRESC_W   = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               frame_start,
    input  logic               deser_en,
    input  logic               sampled_bit,
    input  logic [PRESC_W-1:0] edge_cnt,
    input  logic [PRESC_W-1:0] Prescale,
    input  logic [3:0]         data_len,
    input  logic               msb_first,
    uart_rx_deser_gen_if.master rx_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e               state_q, state_d;
    logic [MAX_WIDTH-1:0] sr_q, sr_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [3:0]           len_q, len_d;
    logic                 msb_q, msb_d;
    logic                 cmpl_q, cmpl_d;
    logic [MAX_WIDTH-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
`ifdef UART_RX_PARITY_CALC_EN
    logic                 par_acc_q, par_acc_d;
    logic                 par_out_q, par_out_d;
`endif

    logic [PRESC_W-1:0]   strobe_tgt;
    logic                 strobe;
    logic [3:0]           len_clamped;
    logic [MAX_WIDTH-1:0] word;
    logic                 accept;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        strobe_tgt = (Prescale >> 1) + PRESC_W'(2);
        strobe     = deser_en && (edge_cnt == strobe_tgt);

        len_clamped = data_len;
        if (data_len < 4'd5)
            len_clamped = 4'd5;
        else if (int'(data_len) > MAX_WIDTH)
            len_clamped = 4'(MAX_WIDTH);

        word   = msb_q ? sr_q : (sr_q >> (MAX_WIDTH - int'(len_q)));
        accept = valid_q && rx_out.out_ready;

        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        len_d     = len_q;
        msb_d     = msb_q;
        cmpl_d    = 1'b0;
        data_d    = data_q;
        valid_d   = valid_q;
        ovr_d     = ovr_q;
`ifdef UART_RX_PARITY_CALC_EN
        par_acc_d = par_acc_q;
        par_out_d = par_out_q;
`endif

        // A new frame wins over any strobe arriving in the same cycle.
        if (frame_start) begin
            state_d   = SHIFT;
            sr_d      = '0;
            bit_cnt_d = '0;
            len_d     = len_clamped;
            msb_d     = msb_first;
`ifdef UART_RX_PARITY_CALC_EN
            par_acc_d = 1'b0;
`endif
        end else if (state_q == SHIFT && strobe) begin
            sr_d      = msb_q ? {sr_q[MAX_WIDTH-2:0], sampled_bit}
                              : {sampled_bit, sr_q[MAX_WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
`ifdef UART_RX_PARITY_CALC_EN
            par_acc_d = par_acc_q ^ sampled_bit;
`endif
            if (bit_cnt_q + 4'd1 == len_q) begin
                state_d = DONE;
                cmpl_d  = 1'b1;
            end
        end

        // sr_q still holds the finished word in the cycle after the last capture.
        if (cmpl_q) begin
            if (!valid_q || rx_out.out_ready) begin
                data_d  = word;
                valid_d = 1'b1;
`ifdef UART_RX_PARITY_CALC_EN
                par_out_d = par_acc_q;
`endif
                if (accept)
                    ovr_d = 1'b0;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            len_q     <= '0;
            msb_q     <= 1'b0;
            cmpl_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_CALC_EN
            par_acc_q <= 1'b0;
            par_out_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            len_q     <= len_d;
            msb_q     <= msb_d;
            cmpl_q    <= cmpl_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_CALC_EN
            par_acc_q <= par_acc_d;
            par_out_q <= par_out_d;
`endif
        end
    end

    assign rx_out.P_DATA     = data_q;
    assign rx_out.data_valid = valid_q;
    assign rx_out.overrun    = ovr_q;
    assign rx_out.busy       = (state_q == SHIFT);
`ifdef UART_RX_PARITY_CALC_EN
    assign rx_out.par_calc   = par_out_q;
`endif

endmodule
